// File: rtl/hl_pkg.sv
// -----------------------------------------------------------------------------
// hl_pkg
//   Shared constants and types for the hidden-layer MAC sequencer.
//   N_INPUT / N_NEURON are the production defaults; the controller exposes them
//   as parameters so smaller configurations can be built from the same source.
// -----------------------------------------------------------------------------
package hl_pkg;

  localparam int N_INPUT  = 784;  // pixels per neuron
  localparam int N_NEURON = 16;   // hidden neurons per layer pass
  localparam int PSUM_W   = 32;   // accumulator width
  localparam int DATA_W   = 8;    // pixel / weight width

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    LAST = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/hl_mac_ctrl.sv
// -----------------------------------------------------------------------------
// hl_mac_ctrl
//   Sequencer for the hidden-layer MAC PE. For every hidden neuron it streams
//   N_INPUT pixel/weight pairs out of the input buffer and the weight ROM,
//   accumulates them through the external combinational PE
//   (ofmap = psum + ifmap(u8) * weight(s8)) in its own psum register, and
//   hands the finished sum downstream over a valid/ready port.
//
// Ports
//   clk, rst              clock (rising edge) / asynchronous active-high reset
//   start                 begin a layer pass (only looked at in IDLE)
//   busy, done            pass in progress / one-cycle end-of-pass pulse
//   rd_en, in_addr,       read strobe and addresses for input buffer and
//   wt_addr               weight ROM (both return data one cycle later)
//   ifmap_q, weight_q     read data from input buffer / weight ROM
//   pe_ifmap, pe_weight,  operands driven to the PE (zero when no read data
//   pe_psum               is arriving), pe_psum is the psum register
//   pe_ofmap              PE result, captured into psum on each data beat
//   out_valid, out_ready  result handshake
//   out_idx, out_data     neuron index and signed accumulated sum
// -----------------------------------------------------------------------------
module hl_mac_ctrl
  import hl_pkg::*;
#(
  parameter int N_INPUT  = hl_pkg::N_INPUT,
  parameter int N_NEURON = hl_pkg::N_NEURON,
  localparam int IA_W = (N_INPUT > 1) ? $clog2(N_INPUT) : 1,
  localparam int WA_W = $clog2(N_INPUT * N_NEURON),
  localparam int NI_W = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IA_W-1:0]   in_addr,
  output logic [WA_W-1:0]   wt_addr,
  input  logic [DATA_W-1:0] ifmap_q,
  input  logic [DATA_W-1:0] weight_q,
  output logic [DATA_W-1:0] pe_ifmap,
  output logic [DATA_W-1:0] pe_weight,
  output logic [PSUM_W-1:0] pe_psum,
  input  logic [PSUM_W-1:0] pe_ofmap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NI_W-1:0]   out_idx,
  output logic [PSUM_W-1:0] out_data
);

  localparam logic [IA_W-1:0] IDX_LAST    = IA_W'(N_INPUT - 1);
  localparam logic [NI_W-1:0] NEURON_LAST = NI_W'(N_NEURON - 1);

  state_e            state_q;
  logic [NI_W-1:0]   neuron_q;
  logic [IA_W-1:0]   idx_q;
  logic [WA_W-1:0]   wt_ptr_q;   // running weight pointer = neuron*N_INPUT + idx
  logic [PSUM_W-1:0] psum_q;
  logic              dvld_q;     // read data present on ifmap_q/weight_q
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic              out_valid_q;

  // Sequencer FSM with registered control outputs and the psum accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      neuron_q    <= '0;
      idx_q       <= '0;
      wt_ptr_q    <= '0;
      psum_q      <= '0;
      dvld_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // Read data follows the strobe by one cycle; every data beat is folded
      // into psum. The state-specific clears below never coincide with a beat.
      dvld_q <= rd_en_q;
      done_q <= 1'b0;
      if (dvld_q) begin
        psum_q <= pe_ofmap;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            neuron_q <= '0;
            idx_q    <= '0;
            wt_ptr_q <= '0;
            psum_q   <= '0;
            rd_en_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end

        RUN: begin
          // The weight pointer is never rewound inside a pass, so it walks
          // the ROM row-major across neurons without a multiplier.
          wt_ptr_q <= wt_ptr_q + WA_W'(1);
          if (idx_q == IDX_LAST) begin
            idx_q   <= '0;
            rd_en_q <= 1'b0;
            state_q <= LAST;
          end else begin
            idx_q <= idx_q + IA_W'(1);
          end
        end

        LAST: begin
          // Final read data lands this cycle; the sum is complete after it.
          out_valid_q <= 1'b1;
          state_q     <= EMIT;
        end

        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (neuron_q == NEURON_LAST) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              neuron_q <= neuron_q + NI_W'(1);
              idx_q    <= '0;
              psum_q   <= '0;
              rd_en_q  <= 1'b1;
              state_q  <= RUN;
            end
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          rd_en_q     <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign in_addr   = idx_q;
  assign wt_addr   = wt_ptr_q;
  // The PE is combinational, so operands are gated to zero between beats.
  assign pe_ifmap  = dvld_q ? ifmap_q  : '0;
  assign pe_weight = dvld_q ? weight_q : '0;
  assign pe_psum   = psum_q;
  assign out_valid = out_valid_q;
  assign out_idx   = neuron_q;
  assign out_data  = psum_q;

endmodule

// File: tb/tb_hl_mac_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hl_mac_ctrl
//   Directed bench for hl_mac_ctrl. A small instance (4 inputs, 2 neurons) with
//   behavioural buffer/ROM/PE models covers the sequencing scenarios; a second
//   instance (784 inputs, 1 neuron) covers the full-length accumulation.
// -----------------------------------------------------------------------------
module tb_hl_mac_ctrl;

  localparam int NI     = 4;
  localparam int NN     = 2;
  localparam int BIG_NI = 784;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- small instance ----------------
  logic        start = 1'b0;
  logic        busy, done, rd_en;
  logic [1:0]  in_addr;
  logic [2:0]  wt_addr;
  logic [7:0]  ifmap_q, weight_q, pe_ifmap, pe_weight;
  logic [31:0] pe_psum, pe_ofmap, out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [0:0]  out_idx;

  byte unsigned img [4] = '{130, 52, 25, 255};
  byte          wts [8] = '{-30, 70, 60, 50, 40, -128, 127, -90};

  hl_mac_ctrl #(.N_INPUT(NI), .N_NEURON(NN)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .in_addr(in_addr), .wt_addr(wt_addr),
    .ifmap_q(ifmap_q), .weight_q(weight_q),
    .pe_ifmap(pe_ifmap), .pe_weight(pe_weight), .pe_psum(pe_psum),
    .pe_ofmap(pe_ofmap), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data)
  );

  // Input buffer / weight ROM with one cycle of read latency
  always @(posedge clk) begin
    if (rd_en) begin
      ifmap_q  <= img[in_addr];
      weight_q <= wts[wt_addr];
    end
  end

  // PE: unsigned pixel times signed weight plus psum
  assign pe_ofmap = pe_psum + ($signed({24'd0, pe_ifmap}) * $signed({{24{pe_weight[7]}}, pe_weight}));

  // ---------------- full-length instance ----------------
  logic        b_start = 1'b0;
  logic        b_busy, b_done, b_rd_en;
  logic [9:0]  b_in_addr, b_wt_addr;
  logic [7:0]  b_ifmap_q, b_weight_q, b_pe_ifmap, b_pe_weight;
  logic [31:0] b_pe_psum, b_pe_ofmap, b_out_data;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [0:0]  b_out_idx;

  hl_mac_ctrl #(.N_INPUT(BIG_NI), .N_NEURON(1)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .in_addr(b_in_addr), .wt_addr(b_wt_addr),
    .ifmap_q(b_ifmap_q), .weight_q(b_weight_q),
    .pe_ifmap(b_pe_ifmap), .pe_weight(b_pe_weight), .pe_psum(b_pe_psum),
    .pe_ofmap(b_pe_ofmap), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_idx(b_out_idx), .out_data(b_out_data)
  );

  // Every pixel 255, every weight -128 (zero outside the valid ranges)
  always @(posedge clk) begin
    if (b_rd_en) begin
      b_ifmap_q  <= (b_in_addr < 10'd784) ? 8'd255 : 8'd0;
      b_weight_q <= (b_wt_addr < 10'd784) ? 8'h80  : 8'h00;
    end
  end

  assign b_pe_ofmap = b_pe_psum + ($signed({24'd0, b_pe_ifmap}) * $signed({{24{b_pe_weight[7]}}, b_pe_weight}));

  // ---------------- checking and recording ----------------
  int n_checks = 0;
  int n_pass   = 0;

  int res_idx[$];
  int res_data[$];
  int wt_tr[$];
  int in_tr[$];
  int done_cnt, busy_cnt, cyc, first_valid;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_rec();
    res_idx.delete(); res_data.delete(); wt_tr.delete(); in_tr.delete();
    done_cnt = 0; busy_cnt = 0; cyc = 0; first_valid = -1;
  endtask

  // Advance one clock; sample small-instance outputs 1ns after the edge.
  task automatic step();
    if (out_valid && out_ready) begin
      res_idx.push_back(int'(out_idx));
      res_data.push_back(int'($signed(out_data)));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (rd_en) begin
      wt_tr.push_back(int'(wt_addr));
      in_tr.push_back(int'(in_addr));
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n;
    n = 0;
    while (!out_valid && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_valid_seen"}, out_valid, 1);
  endtask

  // Nominal pass with out_ready held high: results, timing and address traces.
  task automatic run_nominal(input string tag);
    int bad;
    clear_rec();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_first_rd_en"}, rd_en, 1);
    wait_done(tag, 100);
    chk({tag, "_n_results"}, res_data.size(), 2);
    if (res_data.size() >= 2) begin
      chk({tag, "_idx0"}, res_idx[0], 0);
      chk({tag, "_data0"}, res_data[0], 13990);
      chk({tag, "_idx1"}, res_idx[1], 1);
      chk({tag, "_data1"}, res_data[1], -21231);
    end
    chk({tag, "_busy_cycles"}, busy_cnt, NN * (NI + 2) + 1);
    chk({tag, "_valid_latency"}, first_valid - 1, NI + 1);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    bad = 0;
    if (wt_tr.size() != 8 || in_tr.size() != 8) bad++;
    else begin
      for (int i = 0; i < 8; i++) begin
        if (wt_tr[i] != i) bad++;
        if (in_tr[i] != i % 4) bad++;
      end
    end
    chk({tag, "_addr_trace_errs"}, bad, 0);
    step();
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int bad;
    int n;

    // ---- reset state ----
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_psum", pe_psum, 0);
    chk("rst_wt_addr", wt_addr, 0);
    chk("rst_big_busy", b_busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // ---- scenario 1 / 6: nominal pass and address traces ----
    run_nominal("s1");

    // ---- scenario 2: back-pressure on the first result ----
    clear_rec();
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("s2", 20);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (!(out_valid && $signed(out_data) == 32'sd13990 && out_idx == 1'b0 && !rd_en)) bad++;
      if (k < 4) step();
    end
    chk("s2_hold_errs", bad, 0);
    out_ready = 1'b1;
    step();
    chk("s2_n1_rd_en", rd_en, 1);
    chk("s2_n1_valid_low", out_valid, 0);
    chk("s2_n1_in_addr", in_addr, 0);
    chk("s2_n1_wt_addr", wt_addr, 4);
    wait_done("s2", 100);
    chk("s2_n_results", res_data.size(), 2);
    if (res_data.size() >= 2) begin
      chk("s2_data0", res_data[0], 13990);
      chk("s2_data1", res_data[1], -21231);
    end
    step();

    // ---- scenario 3: start pulses during RUN and EMIT are ignored ----
    clear_rec();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("s3", 20);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("s3", 100);
    for (int k = 0; k < 10; k++) step();
    chk("s3_n_results", res_data.size(), 2);
    chk("s3_done_pulses", done_cnt, 1);
    chk("s3_idle_after", busy, 0);
    chk("s3_wt_reads", wt_tr.size(), 8);

    // ---- scenario 4: reset in the middle of neuron 1 ----
    clear_rec();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(rd_en && wt_addr == 3'd5) && n < 30) begin
      step();
      n++;
    end
    chk("s4_reached_n1", wt_addr, 5);
    rst = 1'b1;
    #2;
    chk("s4_busy", busy, 0);
    chk("s4_done", done, 0);
    chk("s4_rd_en", rd_en, 0);
    chk("s4_out_valid", out_valid, 0);
    chk("s4_in_addr", in_addr, 0);
    chk("s4_wt_addr", wt_addr, 0);
    chk("s4_psum", pe_psum, 0);
    chk("s4_pe_ifmap", pe_ifmap, 0);
    chk("s4_pe_weight", pe_weight, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("s4_n_results", res_data.size(), 1);
    chk("s4_no_done", done_cnt, 0);
    chk("s4_idle", busy, 0);
    run_nominal("s4_rerun");

    // ---- scenario 5: full-length neuron, extreme operands ----
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    n = 0;
    while (!b_out_valid && n < 2000) begin
      step();
      n++;
    end
    chk("s5_valid_latency", n, BIG_NI + 1);
    chk("s5_data", longint'($signed(b_out_data)), -25589760);
    chk("s5_idx", b_out_idx, 0);
    step();
    chk("s5_done", b_done, 1);
    step();
    chk("s5_idle", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
